// File: rtl/rx_fifo_pkg.sv
// Shared communication defaults: the word width and buffer depth used by the sender,
// the receiver, rx_fifo and the benches.
package rx_fifo_pkg;

  localparam int WORD_W     = 16;
  localparam int FIFO_DEPTH = 4;

endpackage : rx_fifo_pkg

// File: rtl/rx_fifo.sv
// Receive-side FIFO between the serial receiver and the word consumer.
// The storage is a resettable register array, so a reset clears every stored word at once.
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int B     = WORD_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clkr,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [B-1:0]  in_data,
  output logic          enr,
  output logic          out_valid,
  output logic [B-1:0]  out_data,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ENR_MAX  = (AW+1)'(DEPTH - 2);

  logic [B-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic pop, push, drop, full;

  assign full      = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  // Falls one slot early: the receiver may already have a word in flight when it sees enr drop.
  assign enr       = (count_q <= ENR_MAX);

  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clkr or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule : rx_fifo

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: a queue-based reference model is checked on every falling edge,
// and hand-computed expectations pin the key scenarios.
module tb_rx_fifo;
  import rx_fifo_pkg::*;

  localparam int B     = WORD_W;
  localparam int DEPTH = FIFO_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  logic          clkr = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [B-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          enr;
  logic          out_valid;
  logic [B-1:0]  out_data;
  logic [AW:0]   count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  int modelQ[$];
  bit modelOvf = 1'b0;
  int rxWords[$];

  rx_fifo #(.B(B), .DEPTH(DEPTH), .AW(AW)) dut (
    .clkr      (clkr),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .enr       (enr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clkr = ~clkr;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a plain queue of words plus a sticky drop flag.
  always @(posedge clkr or posedge rst) begin
    if (rst) begin
      modelQ.delete();
      modelOvf = 1'b0;
    end else begin
      int  sizeBefore;
      bit  doPop;
      sizeBefore = modelQ.size();
      doPop = (sizeBefore != 0) && (out_ready === 1'b1);
      if (doPop) void'(modelQ.pop_front());
      if (in_valid === 1'b1) begin
        if (sizeBefore < DEPTH || doPop) modelQ.push_back(int'(in_data));
        else modelOvf = 1'b1;
      end
    end
  end

  always @(negedge clkr) begin
    checkOutput("model.count", 32'(count), 32'(modelQ.size()));
    checkOutput("model.out_valid", 32'(out_valid), 32'(modelQ.size() != 0));
    checkOutput("model.enr", 32'(enr), 32'(modelQ.size() <= DEPTH - 2));
    checkOutput("model.overflow", 32'(overflow), 32'(modelOvf));
    if (modelQ.size() != 0) checkOutput("model.out_data", 32'(out_data), 32'(modelQ[0]));
  end

  task automatic applyStimulus(input logic iv, input logic [B-1:0] data, input logic ready);
    in_valid  = iv;
    in_data   = data;
    out_ready = ready;
    @(posedge clkr);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clkr);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nextWord;
    int cyc;
    int maxCount;

    #5 rst = 1'b1;
    #15 rst = 1'b0;
    #1;
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.count", 32'(count), 32'd0);
    checkOutput("reset.enr", 32'(enr), 32'd1);
    checkOutput("reset.overflow", 32'(overflow), 32'd0);
    checkOutput("reset.out_data", 32'(out_data), 32'd0);
    @(posedge clkr);
    #1;

    $display("[TB] push 1,2,3 then drain");
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, B'(i), 1'b0);
    checkOutput("p3.count", 32'(count), 32'd3);
    checkOutput("p3.enr", 32'(enr), 32'd0);
    checkOutput("p3.out_data", 32'(out_data), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      checkOutput("p3.drain", 32'(out_data), 32'(i));
      applyStimulus(1'b0, B'(16'hdead), 1'b1);
    end
    checkOutput("p3.empty", 32'(count), 32'd0);

    $display("[TB] overflow drop");
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, B'(i), 1'b0);
    applyStimulus(1'b1, B'(5), 1'b0);
    checkOutput("drop.count", 32'(count), 32'd4);
    checkOutput("drop.overflow", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drop.drain", 32'(out_data), 32'(i));
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("drop.empty", 32'(out_valid), 32'd0);
    checkOutput("drop.sticky", 32'(overflow), 32'd1);

    doReset();
    $display("[TB] full with simultaneous push and pop");
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, B'(i), 1'b0);
    applyStimulus(1'b1, B'(5), 1'b1);
    checkOutput("fullpp.count", 32'(count), 32'd4);
    checkOutput("fullpp.overflow", 32'(overflow), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      checkOutput("fullpp.drain", 32'(out_data), 32'(i));
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("fullpp.empty", 32'(count), 32'd0);

    $display("[TB] stream 1..20 with toggling ready");
    nextWord = 1;
    cyc = 0;
    maxCount = 0;
    rxWords.delete();
    while (rxWords.size() < 20 && cyc < 400) begin
      out_ready = (cyc % 2 == 0);
      if (nextWord <= 20 && enr) begin
        in_valid = 1'b1;
        in_data  = B'(nextWord);
        nextWord++;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && out_ready) rxWords.push_back(int'(out_data));
      if (int'(count) > maxCount) maxCount = int'(count);
      @(posedge clkr);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("stream.received", 32'(rxWords.size()), 32'd20);
    checkOutput("stream.maxcount", 32'(maxCount), 32'd3);
    for (int i = 0; i < rxWords.size(); i++) checkOutput("stream.order", 32'(rxWords[i]), 32'(i + 1));

    $display("[TB] reset mid-transfer");
    applyStimulus(1'b1, B'(16'h00a0), 1'b0);
    applyStimulus(1'b1, B'(16'h00a1), 1'b0);
    checkOutput("midrst.before", 32'(count), 32'd2);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst.count", 32'(count), 32'd0);
    checkOutput("midrst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst.out_data", 32'(out_data), 32'd0);
    @(posedge clkr);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, B'(7), 1'b0);
    checkOutput("midrst.push7", 32'(out_data), 32'd7);
    checkOutput("midrst.valid7", 32'(out_valid), 32'd1);
    checkOutput("midrst.count7", 32'(count), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("midrst.drained", 32'(count), 32'd0);

    @(posedge clkr);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rx_fifo

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 Parameter B, default 16, word bit width (matches the sender/receiver word width).
REQ-002 Parameter DEPTH, default 4, number of word slots; SHALL be a power of two and at least 2.
REQ-003 Parameter AW, default log2(DEPTH), pointer width.
REQ-004 clkr  input  1  receiver-side clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  one-cycle pulse: receiver has delivered a new word.
REQ-007 in_data  input  B  receiver output word; sampled only when in_valid=1.
REQ-008 enr  output  1  receive enable to the upstream receiver; 1 = buffer can absorb further words.
REQ-009 out_valid  output  1  head word available to the consumer.
REQ-010 out_data  output  B  head word.
REQ-011 out_ready  input  1  consumer accepts the head word this cycle.
REQ-012 count  output  AW+1  number of stored words, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: a word was dropped.

Function
REQ-014 Push: in_valid=1 and (count<DEPTH or pop in the same cycle) SHALL write in_data at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-015 Pop: out_valid=1 and out_ready=1 SHALL increment rd_ptr modulo DEPTH.
REQ-016 count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop or on neither.
REQ-017 Full with simultaneous push and pop: both SHALL occur, count stays DEPTH, no drop.
REQ-018 Empty with in_valid=1: word stored, count 0->1; no fall-through, so out_valid stays 0 that cycle and rises after the edge.
REQ-019 Latency: a word pushed at edge N SHALL appear on out_data with out_valid=1 immediately after edge N if the FIFO was empty, else when it reaches the head.
REQ-020 out_valid SHALL equal (count!=0); out_data SHALL equal mem[rd_ptr] combinationally.
REQ-021 enr SHALL equal (count <= DEPTH-2), a pure function of the registered count, leaving one spare slot for a word already in flight when enr falls.
REQ-022 Drop: in_valid=1 while count=DEPTH and no pop SHALL discard the word, leave pointers and count unchanged, and set overflow to 1.
REQ-023 overflow SHALL remain 1 until reset.
REQ-024 Pointer wrap-around SHALL preserve FIFO order indefinitely; word order out SHALL equal word order in.
REQ-025 in_data SHALL be ignored when in_valid=0; out_ready SHALL be ignored when out_valid=0.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for a clock edge, force wr_ptr=0, rd_ptr=0, count=0, overflow=0, and all mem slots=0.
REQ-027 During and after reset, outputs SHALL be out_valid=0, out_data=0, enr=1, count=0, overflow=0.
REQ-028 Reset asserted mid-transfer SHALL discard all stored words; nothing pushed before reset may appear afterwards.

Structure
REQ-029 Default word width (16) and default DEPTH (4) SHALL live in the shared comm package, used by sender, receiver, rx_fifo and the benches.
REQ-030 Single module; no sub-module. Storage is a register array, not inferred RAM, so that the reset requirement holds.

Verification (B=16, DEPTH=4)
REQ-031 Reset at t=5 ns, released at 20 ns -> out_valid=0, count=0, enr=1, overflow=0, out_data=0.
REQ-032 Push 1,2,3 on consecutive cycles with out_ready=0 -> count=3, enr=0 after the third push, out_data=1; then out_ready=1 for 3 cycles -> outputs 1,2,3 in order, count=0.
REQ-033 Fill with 1..4, then in_valid with data 5 and out_ready=0 -> count=4, 5 dropped, overflow=1; drain -> 1,2,3,4 only.
REQ-034 Full (1..4), in_valid with data 5 and out_ready=1 in the same cycle -> count stays 4, no overflow; drain yields 2,3,4,5.
REQ-035 Stream 1..20, one push per cycle, with out_ready toggling 1,0,1,0 -> when the count reaches 3, enr=0 and the bench stops pushing; received sequence 1..20 with no gaps (pointers wrap 5 times).
REQ-036 Store 2 words, assert rst for 1 cycle -> count=0, out_valid=0 at once; next push of 7 -> out_data=7.
